// File: rtl/univ_shift_reg.sv
// Universal shift register: load/clear/shift/rotate/ASR with a valid/ready command port and multi-cycle shift-by-N.
// Optional registered parity on q_par when UNIV_SHIFT_PARITY_EN is defined; otherwise q_par is tied to 0.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AMT_W-1:0] cmd_amt,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  output logic [WIDTH-1:0] q,
  output logic             ser_out_l,
  output logic             ser_out_r,
  output logic             done,
  output logic             q_par,
  output logic             dbg_state
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_SHL   = 3'd1;
  localparam logic [2:0] OP_SHR   = 3'd2;
  localparam logic [2:0] OP_ROL   = 3'd3;
  localparam logic [2:0] OP_ROR   = 3'd4;
  localparam logic [2:0] OP_ASR   = 3'd5;
  localparam logic [2:0] OP_CLEAR = 3'd6;

  logic [0:0]       state_q, state_d;
  logic [AMT_W-1:0] count_q, count_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             done_q, done_d;

  // One single-bit step of a shift/rotate op; serial fills are taken live each step.
  function automatic logic [WIDTH-1:0] step(input logic [2:0] op, input logic [WIDTH-1:0] v,
                                            input logic sl, input logic sr);
    case (op)
      OP_SHL:  step = {v[WIDTH-2:0], sr};
      OP_SHR:  step = {sl, v[WIDTH-1:1]};
      OP_ROL:  step = {v[WIDTH-2:0], v[WIDTH-1]};
      OP_ROR:  step = {v[0], v[WIDTH-1:1]};
      OP_ASR:  step = {v[WIDTH-1], v[WIDTH-1:1]};
      default: step = v;
    endcase
  endfunction

  // Handshake: a command is taken on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, and commands offered while busy are dropped, not queued.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    q_d     = q_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (cmd_valid) begin
        case (cmd_op)
          OP_LOAD: begin
            q_d    = load_data;
            done_d = 1'b1;
          end
          OP_CLEAR: begin
            q_d    = '0;
            done_d = 1'b1;
          end
          OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_ASR: begin
            if (cmd_amt == '0) begin
              done_d = 1'b1;
            end else begin
              op_d    = cmd_op;
              count_d = cmd_amt;
              state_d = RUN;
            end
          end
          default: done_d = 1'b1;
        endcase
      end
    end else begin
      q_d     = step(op_q, q_q, ser_in_l, ser_in_r);
      count_d = count_q - 1'b1;
      if (count_q == AMT_W'(1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      op_q    <= '0;
      q_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      q_q     <= q_d;
      done_q  <= done_d;
    end
  end

`ifdef UNIV_SHIFT_PARITY_EN
  logic par_q, par_d;

  // Parity of the next q so it lines up with q on the same edge.
  always_comb par_d = ^q_d;

  always_ff @(posedge clk) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= par_d;
  end

  assign q_par = par_q;
`else
  assign q_par = 1'b0;
`endif

  assign cmd_ready = (state_q == IDLE);
  assign q         = q_q;
  assign ser_out_l = q_q[WIDTH-1];
  assign ser_out_r = q_q[0];
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8): a vector table of commands with hand-computed results,
// plus hand-written sequences for reset, back-to-back, busy-ignore and mid-run reset.
module tb_univ_shift_reg;

  localparam int WIDTH = 8;
  localparam int AMT_W = 4;
`ifdef UNIV_SHIFT_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_SHL   = 3'd1;
  localparam logic [2:0] OP_SHR   = 3'd2;
  localparam logic [2:0] OP_ROL   = 3'd3;
  localparam logic [2:0] OP_ROR   = 3'd4;
  localparam logic [2:0] OP_ASR   = 3'd5;
  localparam logic [2:0] OP_CLEAR = 3'd6;
  localparam logic [2:0] OP_NOP   = 3'd7;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [AMT_W-1:0] cmd_amt;
  logic [WIDTH-1:0] load_data;
  logic             ser_in_l;
  logic             ser_in_r;
  logic [WIDTH-1:0] q;
  logic             ser_out_l;
  logic             ser_out_r;
  logic             done;
  logic             q_par;
  logic             dbg_state;

  int n_checks;
  int n_errors;
  logic [WIDTH-1:0] cur_q;

  typedef struct {
    logic [2:0]       op;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] data;
    logic             sl;
    logic             sr;
    logic [WIDTH-1:0] exp_q;
  } vec_t;

  vec_t vecs[$];

  univ_shift_reg #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_amt(cmd_amt), .load_data(load_data),
    .ser_in_l(ser_in_l), .ser_in_r(ser_in_r), .q(q),
    .ser_out_l(ser_out_l), .ser_out_r(ser_out_r), .done(done),
    .q_par(q_par), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_par(input logic [WIDTH-1:0] v);
    return PAR_EN ? ^v : 1'b0;
  endfunction

  task automatic check_final(input string name, input logic [WIDTH-1:0] exp);
    check({name, " q"}, 32'(q), 32'(exp));
    check({name, " done"}, 32'(done), 32'd1);
    check({name, " ready"}, 32'(cmd_ready), 32'd1);
    check({name, " ser_out"}, {30'd0, ser_out_l, ser_out_r}, {30'd0, exp[WIDTH-1], exp[0]});
    check({name, " q_par"}, 32'(q_par), 32'(exp_par(exp)));
  endtask

  // Starts at a negedge, ends at the negedge after the final edge of the command.
  task automatic run_cmd(input string name, input vec_t v);
    int steps;
    steps = (v.op == OP_LOAD || v.op == OP_CLEAR || v.op == OP_NOP) ? 0 : int'(v.amt);
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    cmd_amt   = v.amt;
    load_data = v.data;
    ser_in_l  = v.sl;
    ser_in_r  = v.sr;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int k = 0; k < steps; k++) begin
      @(negedge clk);
      check({name, " busy"}, {30'd0, cmd_ready, done}, 32'd0);
      if (k == 0) check({name, " q held at accept"}, 32'(q), 32'(cur_q));
    end
    @(negedge clk);
    check_final(name, v.exp_q);
    cur_q = v.exp_q;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = OP_LOAD;
    cmd_amt   = '0;
    load_data = 8'hFF;
    ser_in_l  = 1'b0;
    ser_in_r  = 1'b0;
    cur_q     = '0;

    vecs.push_back('{OP_LOAD,  4'd0,  8'hA5, 1'b0, 1'b0, 8'hA5});
    vecs.push_back('{OP_ROL,   4'd3,  8'h00, 1'b0, 1'b0, 8'h2D});
    vecs.push_back('{OP_LOAD,  4'd5,  8'h90, 1'b0, 1'b0, 8'h90});
    vecs.push_back('{OP_ASR,   4'd2,  8'h00, 1'b0, 1'b0, 8'hE4});
    vecs.push_back('{OP_SHR,   4'd1,  8'h00, 1'b0, 1'b1, 8'h72});
    vecs.push_back('{OP_LOAD,  4'd0,  8'h01, 1'b0, 1'b0, 8'h01});
    vecs.push_back('{OP_ROR,   4'd9,  8'h00, 1'b1, 1'b1, 8'h80});
    vecs.push_back('{OP_CLEAR, 4'd3,  8'hFF, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{OP_SHL,   4'd4,  8'h00, 1'b0, 1'b1, 8'h0F});
    vecs.push_back('{OP_SHL,   4'd0,  8'h00, 1'b1, 1'b1, 8'h0F});
    vecs.push_back('{OP_NOP,   4'd2,  8'h55, 1'b0, 1'b0, 8'h0F});
    vecs.push_back('{OP_SHR,   4'd3,  8'h00, 1'b1, 1'b0, 8'hE1});
    vecs.push_back('{OP_ASR,   4'd15, 8'h00, 1'b0, 1'b0, 8'hFF});
    vecs.push_back('{OP_LOAD,  4'd0,  8'h5A, 1'b0, 1'b0, 8'h5A});
    vecs.push_back('{OP_SHL,   4'd10, 8'h00, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{OP_LOAD,  4'd0,  8'h81, 1'b0, 1'b0, 8'h81});
    vecs.push_back('{OP_ROL,   4'd1,  8'h00, 1'b0, 1'b0, 8'h03});
    vecs.push_back('{OP_LOAD,  4'd0,  8'h07, 1'b0, 1'b0, 8'h07});
    vecs.push_back('{OP_SHL,   4'd1,  8'h00, 1'b1, 1'b0, 8'h0E});
    vecs.push_back('{OP_LOAD,  4'd0,  8'h03, 1'b0, 1'b0, 8'h03});

    // Reset held two edges with a LOAD offered: nothing may be accepted.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    cmd_valid = 1'b0;
    check("reset q", 32'(q), 32'h0);
    check("reset done", 32'(done), 32'd0);
    check("reset ready", 32'(cmd_ready), 32'd1);
    check("reset q_par", 32'(q_par), 32'd0);

    foreach (vecs[i]) run_cmd($sformatf("vec%0d", i), vecs[i]);

    // Back-to-back single-edge commands: done high on consecutive cycles.
    cmd_valid = 1'b1;
    cmd_op    = OP_LOAD;
    load_data = 8'h11;
    @(negedge clk);
    check_final("b2b first", 8'h11);
    load_data = 8'h22;
    @(negedge clk);
    check_final("b2b second", 8'h22);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("b2b done drops", 32'(done), 32'd0);
    check("b2b q stable", 32'(q), 32'h22);

    // LOAD offered during a busy ROR is ignored until ready returns.
    cur_q = 8'h22;
    run_cmd("pre busy", '{OP_LOAD, 4'd0, 8'h01, 1'b0, 1'b0, 8'h01});
    cmd_valid = 1'b1;
    cmd_op    = OP_ROR;
    cmd_amt   = 4'd2;
    @(posedge clk);
    #1;
    cmd_op    = OP_LOAD;
    load_data = 8'hFF;
    @(negedge clk);
    check("busy e0 q", 32'(q), 32'h01);
    check("busy e0 ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("busy e1 q", 32'(q), 32'h80);
    check("busy e1 ctl", {30'd0, cmd_ready, done}, 32'd0);
    @(negedge clk);
    check_final("busy ror end", 8'h40);
    @(negedge clk);
    check_final("busy load taken", 8'hFF);
    cmd_valid = 1'b0;

    // Reset mid-run: q cleared, back to IDLE, no done pulse afterwards.
    cur_q = 8'hFF;
    run_cmd("pre rst", '{OP_LOAD, 4'd0, 8'h3C, 1'b0, 1'b0, 8'h3C});
    cmd_valid = 1'b1;
    cmd_op    = OP_SHL;
    cmd_amt   = 4'd5;
    ser_in_r  = 1'b0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid-run q", 32'(q), 32'h78);
    check("mid-run state", 32'(dbg_state), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst mid q", 32'(q), 32'h0);
    check("rst mid ready", 32'(cmd_ready), 32'd1);
    check("rst mid done", 32'(done), 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("post rst quiet", {23'd0, done, q}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
